// File: rtl/car_game_pkg.sv
// Shared game constants, state encoding and lane helpers for the car game pipeline.
// Also consumed by draw_dynamic_cars for its lane/car-size parameterisation.
package car_game_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_RUN       = 2'd1,
        ST_CRASH     = 2'd2,
        ST_GAME_OVER = 2'd3
    } game_state_t;

    localparam logic [9:0] LANE0_X = 10'd200;
    localparam logic [9:0] LANE1_X = 10'd308;
    localparam logic [9:0] LANE2_X = 10'd416;

    localparam int CAR_WIDTH_DEF  = 23;
    localparam int CAR_HEIGHT_DEF = 33;

    // Taps 16,14,13,11 expressed as a bit mask over q[15:0]
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // Two random bits pick a lane; the spare code folds onto the middle lane
    function automatic logic [9:0] lane_x(input logic [1:0] sel);
        case (sel)
            2'd0:    return LANE0_X;
            2'd2:    return LANE2_X;
            default: return LANE1_X;
        endcase
    endfunction

    function automatic logic [9:0] next_lane_x(input logic [9:0] x);
        if (x == LANE0_X) return LANE1_X;
        if (x == LANE1_X) return LANE2_X;
        return LANE0_X;
    endfunction

endpackage

// File: rtl/traffic_car_controller_if.sv
// Frame-level control and car position bus between the game controller and the renderer.
interface traffic_car_controller_if;
    logic        frame_tick;
    logic        start;
    logic [9:0]  car_user_x;
    logic [9:0]  car2_x;
    logic [9:0]  car2_y;
    logic [9:0]  car3_x;
    logic [9:0]  car3_y;
    logic        show_cars;
    logic        crash;
    logic [15:0] score;
    logic [1:0]  state;

    modport master (
        output frame_tick, start, car_user_x,
        input  car2_x, car2_y, car3_x, car3_y, show_cars, crash, score, state
    );

    modport slave (
        input  frame_tick, start, car_user_x,
        output car2_x, car2_y, car3_x, car3_y, show_cars, crash, score, state
    );
endinterface

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR (taps 16,14,13,11), seeded on reset.
// Latency: new value 1 clk after each enabled edge. No backpressure.
module lfsr16
    import car_game_pkg::*;
#(
    parameter int OUT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic [OUT_W-1:0] rnd
);

    logic [15:0] q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)  q <= LFSR_SEED;
        else if (en) q <= {q[14:0], ^(q & LFSR_TAPS)};
    end

    assign rnd = q[OUT_W-1:0];

endmodule

// File: rtl/traffic_car_controller.sv
// Game state and opponent car motion/respawn/collision; optional speed ramp via DIFFICULTY_RAMP_EN.
// Latency: outputs update 1 clk after frame_tick. No backpressure: every frame_tick is consumed.
module traffic_car_controller
    import car_game_pkg::*;
#(
    parameter int SCREEN_HEIGHT = 480,
    parameter int CAR_WIDTH     = CAR_WIDTH_DEF,
    parameter int CAR_HEIGHT    = CAR_HEIGHT_DEF,
    parameter int USER_Y        = 420,
    parameter int SPEED_INIT    = 2,
    parameter int SPEED_MAX     = 12,
    parameter int CAR3_START_Y  = 240,
    parameter int CRASH_FRAMES  = 64
) (
    input  logic                    clk,
    input  logic                    rst_n,
    traffic_car_controller_if.slave bus
);

    localparam int SPEED_W = $clog2(SPEED_MAX + 1);
    localparam int CNT_W   = $clog2(CRASH_FRAMES);

    game_state_t    st, st_n;
    logic [9:0]     c2x, c2y, c3x, c3y;
    logic [9:0]     c2x_n, c2y_n, c3x_n, c3y_n;
    logic [15:0]    score, score_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [1:0]     lane_sel;

`ifdef DIFFICULTY_RAMP_EN
    logic [SPEED_W-1:0] speed, speed_n;
    logic [15:0]        s1, s2;
    logic               bump;
`else
    wire  [SPEED_W-1:0] speed = SPEED_W'(SPEED_INIT);
`endif

    lfsr16 #(.OUT_W(2)) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (1'b1),
        .rnd   (lane_sel)
    );

    // All geometry is evaluated 11 bits wide so x+width / y+height never wrap
    function automatic logic overlap(input logic [9:0] ux, input logic [9:0] cx, input logic [9:0] cy);
        logic [10:0] u, x, y;
        u = {1'b0, ux};
        x = {1'b0, cx};
        y = {1'b0, cy};
        return (u < x + 11'(CAR_WIDTH)) && (x < u + 11'(CAR_WIDTH)) &&
               (11'(USER_Y) < y + 11'(CAR_HEIGHT)) && (y < 11'(USER_Y) + 11'(CAR_HEIGHT));
    endfunction

    logic [10:0] y2_sum, y3_sum;
    logic        resp2, resp3, hit, near2, near3;
    logic [9:0]  pick, new2_x, new3_x;
    logic [1:0]  inc;
    logic [16:0] score_sum;

    assign y2_sum    = {1'b0, c2y} + 11'(speed);
    assign y3_sum    = {1'b0, c3y} + 11'(speed);
    assign resp2     = y2_sum >= 11'(SCREEN_HEIGHT);
    assign resp3     = y3_sum >= 11'(SCREEN_HEIGHT);
    assign near2     = {1'b0, c2y} < 11'(2 * CAR_HEIGHT);
    assign near3     = {1'b0, c3y} < 11'(2 * CAR_HEIGHT);
    assign hit       = overlap(bus.car_user_x, c2x, c2y) | overlap(bus.car_user_x, c3x, c3y);
    assign pick      = lane_x(lane_sel);
    assign new2_x    = (pick == c3x && near3) ? next_lane_x(pick) : pick;
    // When both respawn together car3 must never share car2's fresh lane
    assign new3_x    = resp2 ? ((pick == new2_x) ? next_lane_x(pick) : pick)
                             : ((pick == c2x && near2) ? next_lane_x(pick) : pick);
    assign inc       = {1'b0, resp2} + {1'b0, resp3};
    assign score_sum = {1'b0, score} + 17'(inc);

`ifdef DIFFICULTY_RAMP_EN
    assign s1   = score + 16'd1;
    assign s2   = score + 16'd2;
    assign bump = (inc != 2'd0 && score != 16'hFFFF && s1[2:0] == 3'd0) ||
                  (inc == 2'd2 && score <  16'hFFFE && s2[2:0] == 3'd0);
`endif

    always_comb begin
        st_n    = st;
        c2x_n   = c2x;
        c2y_n   = c2y;
        c3x_n   = c3x;
        c3y_n   = c3y;
        score_n = score;
        cnt_n   = cnt;
`ifdef DIFFICULTY_RAMP_EN
        speed_n = speed;
`endif
        if (bus.frame_tick) begin
            case (st)
                ST_IDLE, ST_GAME_OVER: begin
                    if (bus.start) begin
                        st_n    = ST_RUN;
                        c2x_n   = LANE0_X;
                        c2y_n   = 10'd0;
                        c3x_n   = LANE2_X;
                        c3y_n   = 10'(CAR3_START_Y);
                        score_n = 16'd0;
`ifdef DIFFICULTY_RAMP_EN
                        speed_n = SPEED_W'(SPEED_INIT);
`endif
                    end
                end
                ST_RUN: begin
                    if (hit) begin
                        st_n  = ST_CRASH;
                        cnt_n = '0;
                    end else begin
                        c2y_n   = resp2 ? 10'd0 : y2_sum[9:0];
                        c3y_n   = resp3 ? 10'd0 : y3_sum[9:0];
                        if (resp2) c2x_n = new2_x;
                        if (resp3) c3x_n = new3_x;
                        score_n = score_sum[16] ? 16'hFFFF : score_sum[15:0];
`ifdef DIFFICULTY_RAMP_EN
                        if (bump && speed < SPEED_W'(SPEED_MAX)) speed_n = speed + 1'b1;
`endif
                    end
                end
                default: begin
                    if (cnt == CNT_W'(CRASH_FRAMES - 1)) st_n = ST_GAME_OVER;
                    else                                 cnt_n = cnt + 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st    <= ST_IDLE;
            c2x   <= LANE0_X;
            c2y   <= 10'd0;
            c3x   <= LANE2_X;
            c3y   <= 10'(CAR3_START_Y);
            score <= 16'd0;
            cnt   <= '0;
`ifdef DIFFICULTY_RAMP_EN
            speed <= SPEED_W'(SPEED_INIT);
`endif
        end else begin
            st    <= st_n;
            c2x   <= c2x_n;
            c2y   <= c2y_n;
            c3x   <= c3x_n;
            c3y   <= c3y_n;
            score <= score_n;
            cnt   <= cnt_n;
`ifdef DIFFICULTY_RAMP_EN
            speed <= speed_n;
`endif
        end
    end

    assign bus.car2_x    = c2x;
    assign bus.car2_y    = c2y;
    assign bus.car3_x    = c3x;
    assign bus.car3_y    = c3y;
    assign bus.score     = score;
    assign bus.state     = st;
    assign bus.crash     = (st == ST_CRASH) || (st == ST_GAME_OVER);
    assign bus.show_cars = (st == ST_CRASH) ? ~cnt[3] : 1'b1;

endmodule

// File: tb/tb_traffic_car_controller.sv
// Bench for traffic_car_controller: lane-index game model plus pinned directed scenarios.
module tb_traffic_car_controller;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    traffic_car_controller_if bus();

    traffic_car_controller dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int failures = 0;

    // Model: game mode 0..3, cars as lane index + y, everything in plain ints
    int lane_px [3] = '{200, 308, 416};
    int m_mode, m_l2, m_l3, m_y2, m_y3, m_score, m_spd, m_cnt;
    logic [15:0] m_lfsr;

    function automatic int lanemap(input int v);
        if (v == 0) return 0;
        if (v == 2) return 2;
        return 1;
    endfunction

    function automatic bit hits(input int ux, input int lane, input int y);
        int px;
        px = lane_px[lane];
        return (ux < px + 23) && (px < ux + 23) && (420 < y + 33) && (y < 420 + 33);
    endfunction

    task automatic model_reload();
        m_mode = 1; m_l2 = 0; m_l3 = 2; m_y2 = 0; m_y3 = 240; m_score = 0; m_spd = 2;
    endtask

    task automatic model_reset();
        m_mode = 0; m_l2 = 0; m_l3 = 2; m_y2 = 0; m_y3 = 240; m_score = 0; m_spd = 2;
        m_cnt = 0; m_lfsr = 16'hACE1;
    endtask

    task automatic add_score();
        if (m_score < 65535) begin
            m_score++;
`ifdef DIFFICULTY_RAMP_EN
            if (m_score % 8 == 0 && m_spd < 12) m_spd++;
`endif
        end
    endtask

    task automatic model_tick(input bit st, input int ux);
        int n2, n3, pick, nl2, nl3;
        bit r2, r3;
        case (m_mode)
            0, 3: if (st) model_reload();
            1: begin
                if (hits(ux, m_l2, m_y2) || hits(ux, m_l3, m_y3)) begin
                    m_mode = 2;
                    m_cnt  = 0;
                end else begin
                    n2 = m_y2 + m_spd;
                    n3 = m_y3 + m_spd;
                    r2 = (n2 >= 480);
                    r3 = (n3 >= 480);
                    pick = lanemap(int'(m_lfsr[1:0]));
                    nl2 = pick;
                    if (nl2 == m_l3 && m_y3 < 66) nl2 = (nl2 + 1) % 3;
                    nl3 = pick;
                    if (r2) begin
                        if (nl3 == nl2) nl3 = (nl3 + 1) % 3;
                    end else if (nl3 == m_l2 && m_y2 < 66) begin
                        nl3 = (nl3 + 1) % 3;
                    end
                    if (r2) begin m_l2 = nl2; m_y2 = 0; add_score(); end
                    else m_y2 = n2;
                    if (r3) begin m_l3 = nl3; m_y3 = 0; add_score(); end
                    else m_y3 = n3;
                end
            end
            default: begin
                if (m_cnt == 63) m_mode = 3;
                else m_cnt++;
            end
        endcase
    endtask

    task automatic cmp_model();
        int es;
        es = (m_mode == 2) ? (((m_cnt >> 3) & 1) == 1 ? 0 : 1) : 1;
        checks++;
        if (int'(bus.state) != m_mode || int'(bus.car2_x) != lane_px[m_l2] || int'(bus.car2_y) != m_y2 ||
            int'(bus.car3_x) != lane_px[m_l3] || int'(bus.car3_y) != m_y3 ||
            int'(bus.score) != m_score || int'(bus.show_cars) != es ||
            int'(bus.crash) != ((m_mode >= 2) ? 1 : 0)) begin
            failures++;
            $display("FAIL model t=%0t: got st=%0d c2=(%0d,%0d) c3=(%0d,%0d) sc=%0d show=%0d crash=%0d; want st=%0d c2=(%0d,%0d) c3=(%0d,%0d) sc=%0d show=%0d crash=%0d",
                     $time, bus.state, bus.car2_x, bus.car2_y, bus.car3_x, bus.car3_y, bus.score,
                     bus.show_cars, bus.crash, m_mode, lane_px[m_l2], m_y2, lane_px[m_l3], m_y3,
                     m_score, es, (m_mode >= 2) ? 1 : 0);
        end
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    // One clock: drive at negedge, model follows the sampling edge, compare at next negedge
    task automatic cycle(input bit ft, input bit st, input int ux);
        bus.frame_tick = ft;
        bus.start      = st;
        bus.car_user_x = 10'(ux);
        @(posedge clk);
        if (ft) model_tick(st, ux);
        m_lfsr = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
        @(negedge clk);
        cmp_model();
    endtask

    task automatic async_reset();
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        cmp_model();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int ux;
        rst_n = 1'b0;
        bus.frame_tick = 1'b0;
        bus.start      = 1'b0;
        bus.car_user_x = 10'd0;
        model_reset();
        repeat (2) @(negedge clk);
        cmp_model();
        chk("rst_state", int'(bus.state), 0);
        chk("rst_car2_x", int'(bus.car2_x), 200);
        chk("rst_car2_y", int'(bus.car2_y), 0);
        chk("rst_car3_x", int'(bus.car3_x), 416);
        chk("rst_car3_y", int'(bus.car3_y), 240);
        chk("rst_show", int'(bus.show_cars), 1);
        chk("rst_crash", int'(bus.crash), 0);
        chk("rst_score", int'(bus.score), 0);
        rst_n = 1'b1;

        cycle(1'b0, 1'b1, 0);
        chk("start_no_tick", int'(bus.state), 0);
        cycle(1'b1, 1'b1, 0);
        chk("start_run", int'(bus.state), 1);
        // start held high during RUN must not reload the game
        repeat (10) cycle(1'b1, 1'b1, 0);
        chk("run_car2_y", int'(bus.car2_y), 20);
        chk("run_car3_y", int'(bus.car3_y), 260);

        repeat (65) cycle(1'b1, 1'b1, 416);
        chk("crash_state", int'(bus.state), 2);
        chk("crash_car3_y", int'(bus.car3_y), 388);
        chk("crash_car2_y", int'(bus.car2_y), 148);
        chk("crash_flag", int'(bus.crash), 1);
        repeat (8) cycle(1'b1, 1'b1, 416);
        chk("crash_blink", int'(bus.show_cars), 0);
        repeat (56) cycle(1'b1, 1'b0, 416);
        chk("gover_state", int'(bus.state), 3);
        chk("gover_crash", int'(bus.crash), 1);
        chk("gover_show", int'(bus.show_cars), 1);

        cycle(1'b1, 1'b1, 0);
        chk("restart_state", int'(bus.state), 1);
        chk("restart_car3_y", int'(bus.car3_y), 240);
        repeat (75) cycle(1'b1, 1'b0, 416);
        chk("crash2_state", int'(bus.state), 2);
        repeat (30) cycle(1'b1, 1'b0, 416);
        chk("crash2_cnt30_show", int'(bus.show_cars), 0);
        async_reset();
        chk("arst_state", int'(bus.state), 0);
        chk("arst_show", int'(bus.show_cars), 1);
        chk("arst_crash", int'(bus.crash), 0);
        chk("arst_car3_y", int'(bus.car3_y), 240);

        ux = 0;
        for (int i = 0; i < 30000; i++) begin
            if (i % 300 == 0) begin
                case ($urandom_range(0, 5))
                    0: ux = 0;
                    1: ux = 600;
                    2: ux = 200;
                    3: ux = 308;
                    4: ux = 416;
                    default: ux = int'($urandom_range(0, 639));
                endcase
            end
            if ($urandom_range(0, 4999) == 0) async_reset();
            else cycle($urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0, ux);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
